// File: rtl/ssriscv_imem_loader.sv
// ----------------------------------------------------------------------------
// ssriscv_imem_loader
//
// Synthesizable program loader for the ssriscv single-cycle core. A framed
// program arrives as a byte stream (valid/ready) and is written word by word
// into the instruction memory write port. The core is held in reset while a
// frame is being loaded and released once the frame has been written.
//
// Frame: LEN_LO, LEN_HI (word count N, little-endian), then N words of four
// little-endian bytes each. With SSRISCV_LOADER_CKSUM_EN defined, one trailing
// byte carries the XOR of all payload bytes and must match for the core to be
// released.
//
// Optional feature macro: SSRISCV_LOADER_CKSUM_EN
//
// Ports:
//   clk         core clock, rising edge
//   rst_n       asynchronous active-low reset
//   byte_valid  byte_data holds a valid byte
//   byte_data   stream byte
//   byte_ready  loader accepts a byte this cycle (decode of state)
//   load_req    single-cycle pulse, restarts loading from RUN or ERR
//   imem_we     instruction memory write strobe, one cycle per word
//   imem_addr   word address
//   imem_wdata  word to write
//   cpu_rst_n   active-low reset to the core, low while loading
//   done        program loaded, core running
//   error       frame rejected
// ----------------------------------------------------------------------------
module ssriscv_imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
`ifdef SSRISCV_LOADER_CKSUM_EN
        S_CKSUM,
`endif
        S_RUN,
        S_ERR
    } state_t;

    // State entered once the payload (possibly empty) has been consumed.
`ifdef SSRISCV_LOADER_CKSUM_EN
    localparam state_t S_AFTER_PAYLOAD = S_CKSUM;
`else
    localparam state_t S_AFTER_PAYLOAD = S_RUN;
`endif

    state_t              state_q, state_d;
    logic [7:0]          len_lo_q, len_lo_d;
    logic [15:0]         len_q, len_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [ADDR_W-1:0]   wcnt_q, wcnt_d;
    logic [23:0]         shift_q, shift_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                run_q, run_d;
    logic                error_q, error_d;
`ifdef SSRISCV_LOADER_CKSUM_EN
    logic [7:0]          cksum_q, cksum_d;
`endif

    logic                accept;
    logic [15:0]         len_full;
    logic                last_word;

    always_comb begin
        byte_ready = 1'b0;
        case (state_q)
            S_LEN_LO, S_LEN_HI, S_DATA: byte_ready = 1'b1;
`ifdef SSRISCV_LOADER_CKSUM_EN
            S_CKSUM:                    byte_ready = 1'b1;
`endif
            default:                    byte_ready = 1'b0;
        endcase
    end

    assign accept    = byte_valid && byte_ready;
    assign len_full  = {byte_data, len_lo_q};
    // len_q >= 1 whenever S_DATA is active, so the subtraction cannot wrap there.
    assign last_word = (16'(wcnt_q) == (len_q - 16'd1));

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        bcnt_d   = bcnt_q;
        wcnt_d   = wcnt_q;
        shift_d  = shift_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        run_d    = 1'b0;
        error_d  = 1'b0;
`ifdef SSRISCV_LOADER_CKSUM_EN
        cksum_d  = cksum_q;
`endif

        case (state_q)
            S_LEN_LO: begin
                if (accept) begin
                    len_lo_d = byte_data;
                    state_d  = S_LEN_HI;
`ifdef SSRISCV_LOADER_CKSUM_EN
                    cksum_d  = 8'h00;
`endif
                end
            end

            S_LEN_HI: begin
                if (accept) begin
                    len_d  = len_full;
                    wcnt_d = '0;
                    bcnt_d = 2'd0;
                    if (32'(len_full) > 32'(DEPTH)) begin
                        state_d = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_AFTER_PAYLOAD;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
                    // Bytes enter at the top so byte 0 ends up in bits 7:0.
                    shift_d = {byte_data, shift_q[23:8]};
                    bcnt_d  = bcnt_q + 2'd1;
`ifdef SSRISCV_LOADER_CKSUM_EN
                    cksum_d = cksum_q ^ byte_data;
`endif
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = wcnt_q;
                        wdata_d = {byte_data, shift_q};
                        wcnt_d  = wcnt_q + ADDR_W'(1);
                        if (last_word) begin
                            state_d = S_AFTER_PAYLOAD;
                        end
                    end
                end
            end

`ifdef SSRISCV_LOADER_CKSUM_EN
            S_CKSUM: begin
                if (accept) begin
                    state_d = (byte_data == cksum_q) ? S_RUN : S_ERR;
                end
            end
`endif

            S_RUN: begin
                if (load_req) begin
                    state_d = S_LEN_LO;
                end
            end

            S_ERR: begin
                if (load_req) begin
                    state_d = S_LEN_LO;
                end
            end

            default: state_d = S_LEN_LO;
        endcase

        // Release is registered from the state register, so it lands one
        // cycle after S_RUN entry, after the final write strobe.
        run_d   = (state_q == S_RUN) && !load_req;
        error_d = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_LEN_LO;
            len_lo_q <= 8'h00;
            len_q    <= 16'h0000;
            bcnt_q   <= 2'd0;
            wcnt_q   <= '0;
            shift_q  <= 24'h000000;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0000_0000;
            run_q    <= 1'b0;
            error_q  <= 1'b0;
`ifdef SSRISCV_LOADER_CKSUM_EN
            cksum_q  <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            bcnt_q   <= bcnt_d;
            wcnt_q   <= wcnt_d;
            shift_q  <= shift_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            run_q    <= run_d;
            error_q  <= error_d;
`ifdef SSRISCV_LOADER_CKSUM_EN
            cksum_q  <= cksum_d;
`endif
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst_n  = run_q;
    assign done       = run_q;
    assign error      = error_q;

endmodule

// File: tb/tb_ssriscv_imem_loader.sv
module tb_ssriscv_imem_loader;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
`ifdef SSRISCV_LOADER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              load_req;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst_n;
    logic              done;
    logic              error;

    ssriscv_imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .load_req   (load_req),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (frame level) ----------------
    // The model keeps the bytes of the current frame and derives every
    // expected output from the frame contents and byte count.
    logic [7:0]  frame[$];
    bit          fin = 1'b0;       // frame fully received and accepted
    bit          rej = 1'b0;       // frame rejected
    bit          m_ready = 1'b1;
    bit          m_we = 1'b0;
    bit          m_run = 1'b0;
    bit          m_err = 1'b0;
    logic [7:0]  m_addr = 8'h00;
    logic [31:0] m_wdata = 32'h0;
    logic [39:0] wr_log[$];        // DUT writes as {addr, data}

    task automatic model_accept(input logic [7:0] b);
        int n;
        int len;
        int k;
        int base;
        logic [7:0] x;
        frame.push_back(b);
        n = frame.size();
        len = (n >= 2) ? int'({frame[1], frame[0]}) : 0;
        if (n == 2) begin
            if (len > DEPTH) rej = 1'b1;
            else if (len == 0 && !CK) fin = 1'b1;
        end else if (n > 2 && n <= 2 + 4 * len) begin
            if ((n - 2) % 4 == 0) begin
                k    = (n - 2) / 4 - 1;
                base = 2 + 4 * k;
                m_we    = 1'b1;
                m_addr  = k[7:0];
                m_wdata = {frame[base+3], frame[base+2], frame[base+1], frame[base]};
                if (!CK && n == 2 + 4 * len) fin = 1'b1;
            end
        end else if (CK && n == 3 + 4 * len) begin
            x = 8'h00;
            for (int i = 2; i < n - 1; i++) x ^= frame[i];
            if (b == x) fin = 1'b1;
            else rej = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        bit prev_fin;
        if (!rst_n) begin
            frame.delete();
            fin = 1'b0; rej = 1'b0;
            m_ready = 1'b1; m_we = 1'b0; m_run = 1'b0; m_err = 1'b0;
            m_addr = 8'h00; m_wdata = 32'h0;
        end else begin
            prev_fin = fin;
            m_we = 1'b0;
            if (load_req && (fin || rej)) begin
                frame.delete();
                fin = 1'b0;
                rej = 1'b0;
            end else if (byte_valid && m_ready) begin
                model_accept(byte_data);
            end
            m_run   = prev_fin && !load_req;
            m_err   = rej;
            m_ready = !(fin || rej);
        end
        #1;
        chk("byte_ready", byte_ready, m_ready);
        chk("imem_we",    imem_we,    m_we);
        chk("imem_addr",  imem_addr,  m_addr);
        chk("imem_wdata", imem_wdata, m_wdata);
        chk("cpu_rst_n",  cpu_rst_n,  m_run);
        chk("done",       done,       m_run);
        chk("error",      error,      m_err);
        if (imem_we === 1'b1) wr_log.push_back({imem_addr, imem_wdata});
    end

    // ---------------- stimulus ----------------
    logic [31:0] fw[$];   // words of the next frame

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            load_req   = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b, input int gmax, input bit ign);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        load_req   = (ign && $urandom_range(0, 7) == 0);
        if (gmax > 0) idle($urandom_range(0, gmax));
    endtask

    task automatic pulse_load();
        @(negedge clk);
        byte_valid = 1'b0;
        load_req   = 1'b1;
        @(negedge clk);
        load_req   = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [7:0] ck_flip, input int gmax,
                              input int gap_at, input int gap_len, input bit ign);
        logic [7:0]  b[$];
        logic [7:0]  x;
        logic [31:0] w;
        logic [15:0] l16;
        l16 = len[15:0];
        x = 8'h00;
        b.push_back(l16[7:0]);
        b.push_back(l16[15:8]);
        if (len <= DEPTH) begin
            for (int i = 0; i < len; i++) begin
                w = fw[i];
                for (int j = 0; j < 4; j++) begin
                    b.push_back(w[8*j +: 8]);
                    x ^= w[8*j +: 8];
                end
            end
            if (CK) b.push_back(x ^ ck_flip);
        end
        for (int i = 0; i < b.size(); i++) begin
            send(b[i], (i == gap_at) ? 0 : gmax, ign);
            if (i == gap_at) idle(gap_len);
        end
        if (len > DEPTH) begin
            // Trailing bytes that must be ignored after the rejection.
            send(8'hA5, 0, 1'b0);
            send(8'h5A, 0, 1'b0);
        end
        idle(3);
    endtask

    task automatic chk_reset_literals(input string tag);
        chk({tag, "_rst_we"},    imem_we,    1'b0);
        chk({tag, "_rst_addr"},  imem_addr,  8'h00);
        chk({tag, "_rst_wdata"}, imem_wdata, 32'h0);
        chk({tag, "_rst_cpu"},   cpu_rst_n,  1'b0);
        chk({tag, "_rst_done"},  done,       1'b0);
        chk({tag, "_rst_err"},   error,      1'b0);
        chk({tag, "_rst_ready"}, byte_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        load_req   = 1'b0;
        #2;
        chk_reset_literals("init");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Two-word frame, continuous valid.
        fw = '{32'h0050_0093, 32'h00A0_0113};
        wr_log.delete();
        send_frame(2, 8'h00, 0, -1, 0, 1'b0);
        chk("tp1_nwr", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("tp1_wr0", wr_log[0], {8'h00, 32'h0050_0093});
            chk("tp1_wr1", wr_log[1], {8'h01, 32'h00A0_0113});
        end
        chk("tp1_done", done, 1'b1);
        chk("tp1_cpu",  cpu_rst_n, 1'b1);
        chk("tp1_ready", byte_ready, 1'b0);

        // Same frame with a 3-cycle valid gap inside word 0.
        pulse_load();
        wr_log.delete();
        send_frame(2, 8'h00, 0, 4, 3, 1'b0);
        chk("tp2_nwr", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("tp2_wr0", wr_log[0], {8'h00, 32'h0050_0093});
            chk("tp2_wr1", wr_log[1], {8'h01, 32'h00A0_0113});
        end

        // Oversized length is rejected, then recovery.
        pulse_load();
        wr_log.delete();
        send_frame(257, 8'h00, 0, -1, 0, 1'b0);
        chk("tp3_err", error, 1'b1);
        chk("tp3_cpu", cpu_rst_n, 1'b0);
        chk("tp3_nwr", wr_log.size(), 0);
        pulse_load();
        chk("tp3_errclr", error, 1'b0);
        fw = '{32'hDEAD_BEEF};
        send_frame(1, 8'h00, 1, -1, 0, 1'b1);
        chk("tp3_done", done, 1'b1);

        // Reload from RUN.
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk("tp4_cpu_drop", cpu_rst_n, 1'b0);
        fw = '{32'h0000_006F};
        wr_log.delete();
        send_frame(1, 8'h00, 0, -1, 0, 1'b0);
        chk("tp4_nwr", wr_log.size(), 1);
        if (wr_log.size() == 1) chk("tp4_wr0", wr_log[0], {8'h00, 32'h0000_006F});
        chk("tp4_cpu", cpu_rst_n, 1'b1);

        // Reset asserted after the 5th byte of a 2-word frame.
        pulse_load();
        send(8'h02, 0, 1'b0);
        send(8'h00, 0, 1'b0);
        send(8'h11, 0, 1'b0);
        send(8'h22, 0, 1'b0);
        send(8'h33, 0, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_literals("mid");
        @(negedge clk);
        rst_n = 1'b1;
        fw = '{32'h1234_5678, 32'h9ABC_DEF0};
        wr_log.delete();
        send_frame(2, 8'h00, 0, -1, 0, 1'b0);
        chk("tp5_nwr", wr_log.size(), 2);
        if (wr_log.size() == 2) chk("tp5_wr0", wr_log[0], {8'h00, 32'h1234_5678});

`ifdef SSRISCV_LOADER_CKSUM_EN
        // Checksum match (C3) and mismatch (C4).
        pulse_load();
        fw = '{32'h0050_0093};
        send_frame(1, 8'h00, 0, -1, 0, 1'b0);
        chk("ck_done", done, 1'b1);
        pulse_load();
        send_frame(1, 8'h07, 0, -1, 0, 1'b0);
        chk("ck_err", error, 1'b1);
        chk("ck_cpu", cpu_rst_n, 1'b0);
`endif

        // Full-depth frame: last write lands on the final address.
        pulse_load();
        fw.delete();
        for (int i = 0; i < DEPTH; i++) fw.push_back($urandom);
        wr_log.delete();
        send_frame(DEPTH, 8'h00, 0, -1, 0, 1'b0);
        chk("full_nwr", wr_log.size(), DEPTH);
        if (wr_log.size() == DEPTH) chk("full_last_addr", wr_log[DEPTH-1][39:32], 8'hFF);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            pulse_load();
            case ($urandom_range(0, 7))
                0:       len = $urandom_range(DEPTH + 1, 65535);
                1:       len = 0;
                default: len = $urandom_range(1, 8);
            endcase
            fw.delete();
            for (int i = 0; i < 8; i++) fw.push_back($urandom);
            send_frame(len, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                       $urandom_range(0, 3), -1, 0, 1'b1);
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ssriscv_imem_loader.md
Name: ssriscv_imem_loader

Overview:
- Hardware program loader for the ssriscv single-cycle core; replaces the simulation-only instruction memory preload with a synthesizable byte-stream writer.
- Receives a framed program over a valid/ready byte interface and writes 32-bit words into the instruction memory write port.
- Holds the CPU in reset while loading and releases it once the frame completes.
- Sits between an external byte source (UART receiver, debug bridge or bench driver) and the IFU instruction memory.

Parameters:
DEPTH, 256, instruction memory depth in 32-bit words.
ADDR_W, 8, word-address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
clk  input  1  core clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
byte_valid  input  1  byte_data holds a valid byte.
byte_data  input  8  stream byte.
byte_ready  output  1  loader accepts a byte this cycle.
load_req  input  1  single-cycle pulse; restarts loading from RUN or ERR.
imem_we  output  1  instruction memory write strobe, one cycle per word.
imem_addr  output  ADDR_W  word address.
imem_wdata  output  32  word to write.
cpu_rst_n  output  1  active-low reset to the core; low while loading.
done  output  1  program loaded, CPU running.
error  output  1  frame rejected.

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N words, each 4 bytes little-endian (byte 0 is bits 7:0).
- A byte is accepted at a rising edge where byte_valid && byte_ready. byte_ready is a combinational decode of state: 1 in S_LEN_LO, S_LEN_HI, S_DATA, S_CKSUM; 0 in S_RUN and S_ERR.
- Reset values (async, while rst_n low):
  - state = S_LEN_LO
  - imem_we = 0, imem_addr = 0, imem_wdata = 0
  - cpu_rst_n = 0, done = 0, error = 0
  - byte counter = 0, word counter = 0
- Reset asserted mid-frame discards the partial frame; the next frame starts from LEN_LO.
- States and transitions:
  - S_LEN_LO: accept byte -> store low length byte; go to S_LEN_HI.
  - S_LEN_HI: accept byte -> form N.
    - N > DEPTH -> S_ERR.
    - N == 0 -> S_CKSUM if the checksum feature is compiled in, otherwise S_RUN.
    - Otherwise -> S_DATA with word counter = 0.
  - S_DATA: assemble bytes into a shift register. On the edge accepting the 4th byte of word k, register imem_we = 1, imem_addr = k and the assembled imem_wdata. The write is visible for exactly the following cycle; imem_we returns to 0 unless another word completes.
    - When word N-1 completes -> S_CKSUM if compiled in, else S_RUN.
  - S_RUN: cpu_rst_n = 1 and done = 1 from the edge after entry. This guarantees the final imem_we cycle precedes reset release.
    - load_req -> S_LEN_LO; cpu_rst_n and done drop to 0 on the same edge.
  - S_ERR: error = 1, cpu_rst_n held 0, input ignored.
    - load_req -> S_LEN_LO; error clears on the same edge.
- load_req is ignored in the loading states.
- Byte-valid gaps of any length are allowed mid-word; the partial word is held.
- Addresses are written sequentially from 0, with no wrap (N <= DEPTH is enforced). Words at addresses >= N keep their previous contents.

Optional Feature:
- Macro: SSRISCV_LOADER_CKSUM_EN.
- Defined: S_CKSUM expects one trailing byte equal to the XOR of all payload bytes (length bytes excluded; 0x00 when N == 0).
  - Match -> S_RUN.
  - Mismatch -> S_ERR.
  - Words already written are not rolled back; the CPU stays in reset.
- Undefined: S_CKSUM does not exist; the frame ends after the last word.

Test Plan:
- Frame 02 00 | 93 00 50 00 | 13 01 A0 00, continuous valid -> imem_we pulses with addr 0 data 0x00500093, then addr 1 data 0x00A00113. cpu_rst_n and done go 1 one cycle after the second write. byte_ready = 0 afterwards.
- Same frame with byte_valid dropped for 3 cycles between bytes 2 and 3 of word 0 -> identical writes and data; no extra imem_we pulse.
- Length 0x0101 (257) with DEPTH = 256 -> error = 1 after LEN_HI, no imem_we, cpu_rst_n stays 0. load_req then a valid frame -> error clears, load succeeds.
- While in S_RUN, pulse load_req, then send 01 00 | 6F 00 00 00 -> cpu_rst_n drops on the load_req edge, addr 0 is rewritten to 0x0000006F, and cpu_rst_n rises again after the write.
- rst_n pulsed low after the 5th byte of a 2-word frame -> all outputs return to reset values. A fresh full frame then loads correctly starting at address 0.
- SSRISCV_LOADER_CKSUM_EN: 01 00 | 93 00 50 00 | C3 -> S_RUN, done = 1. Repeat with trailing C4 -> error = 1, cpu_rst_n = 0.
